// File: rtl/vz_image_loader.sv
// VZ/tape image loader: parses the ioctl header, streams the body into RAM through an
// ack handshake, then patches BASIC pointers or the MCODE start vector.
module vz_image_loader #(
   parameter int          ADDR_W      = 16,
   parameter int          IOCTL_AW    = 24,
   parameter int          HDR_LEN     = 24,
   parameter bit          CHECK_MAGIC = 1'b1,
   parameter logic [7:0]  BASIC_TYPE  = 8'hF0,
   parameter logic [7:0]  MCODE_TYPE  = 8'hF1,
   parameter bit          AUTO_EXEC   = 1'b1
) (
   input  logic                I_CLK,
   input  logic                I_RST,
   input  logic                ioctl_download,
   input  logic                ioctl_wr,
   input  logic [IOCTL_AW-1:0] ioctl_addr,
   input  logic [7:0]          ioctl_data,
   output logic                ioctl_wait,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [7:0]          mem_data,
   output logic                mem_wr,
   input  logic                mem_ack,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [1:0]          err_code,
   output logic [ADDR_W-1:0]   execute_addr,
   output logic                execute_enable,
   output logic                led
);

   localparam logic [IOCTL_AW-1:0] TYPE_OFS = IOCTL_AW'(HDR_LEN - 3);
   localparam logic [IOCTL_AW-1:0] START_LO = IOCTL_AW'(HDR_LEN - 2);
   localparam logic [IOCTL_AW-1:0] START_HI = IOCTL_AW'(HDR_LEN - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_HEADER, S_BODY, S_WAIT_ACK, S_PATCH, S_PATCH_ACK, S_EXEC, S_DONE, S_ERROR
   } state_t;

   state_t              state;
   logic                dl_q;
   logic [7:0]          type_q;
   logic [7:0]          start_lo;
   logic [ADDR_W-1:0]   start;
   logic [ADDR_W-1:0]   cur_addr;
   logic [2:0]          pidx;
   logic                is_mcode;
   logic                type_ok;
   logic [15:0]         s16, e16;
   logic [15:0]         p_addr;
   logic [7:0]          p_data;
   logic                p_last;

   assign is_mcode = (type_q == MCODE_TYPE);
   assign type_ok  = (type_q == MCODE_TYPE) || (type_q == BASIC_TYPE);
   assign s16      = 16'(start);
   assign e16      = 16'(cur_addr);
   assign p_last   = is_mcode ? (pidx == 3'd1) : (pidx == 3'd7);
   assign busy     = !(state inside {S_IDLE, S_DONE, S_ERROR});
   assign led      = busy;

   // cur_addr holds the first free byte after the body, i.e. the BASIC end pointer
   always_comb begin
      p_addr = 16'h0000;
      p_data = 8'h00;
      if (is_mcode) begin
         case (pidx)
            3'd0:    begin p_addr = 16'h788F; p_data = s16[15:8]; end
            default: begin p_addr = 16'h788E; p_data = s16[7:0];  end
         endcase
      end else begin
         case (pidx)
            3'd0:    begin p_addr = 16'h78A5; p_data = s16[15:8]; end
            3'd1:    begin p_addr = 16'h78A4; p_data = s16[7:0];  end
            3'd2:    begin p_addr = 16'h78FA; p_data = e16[15:8]; end
            3'd3:    begin p_addr = 16'h78F9; p_data = e16[7:0];  end
            3'd4:    begin p_addr = 16'h78FC; p_data = e16[15:8]; end
            3'd5:    begin p_addr = 16'h78FB; p_data = e16[7:0];  end
            3'd6:    begin p_addr = 16'h78FE; p_data = e16[15:8]; end
            default: begin p_addr = 16'h78FD; p_data = e16[7:0];  end
         endcase
      end
   end

   always_ff @(posedge I_CLK) begin
      if (I_RST) begin
         state          <= S_IDLE;
         dl_q           <= 1'b0;
         type_q         <= 8'h00;
         start_lo       <= 8'h00;
         start          <= '0;
         cur_addr       <= '0;
         pidx           <= 3'd0;
         ioctl_wait     <= 1'b0;
         mem_addr       <= '0;
         mem_data       <= 8'h00;
         mem_wr         <= 1'b0;
         done           <= 1'b0;
         error          <= 1'b0;
         err_code       <= 2'd0;
         execute_addr   <= '0;
         execute_enable <= 1'b0;
      end else begin
         dl_q           <= ioctl_download;
         execute_enable <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (ioctl_download && !dl_q) begin
                  state    <= S_HEADER;
                  done     <= 1'b0;
                  error    <= 1'b0;
                  err_code <= 2'd0;
                  pidx     <= 3'd0;
               end
            end
            S_HEADER: begin
               if (!ioctl_download) begin
                  state    <= S_ERROR;
                  error    <= 1'b1;
                  err_code <= 2'd3;
               end else if (ioctl_wr) begin
                  if (CHECK_MAGIC && ((ioctl_addr == '0 && ioctl_data != 8'h56) ||
                                      (ioctl_addr == IOCTL_AW'(1) && ioctl_data != 8'h5A))) begin
                     state    <= S_ERROR;
                     error    <= 1'b1;
                     err_code <= 2'd1;
                  end else if (ioctl_addr == TYPE_OFS) begin
                     type_q <= ioctl_data;
                  end else if (ioctl_addr == START_LO) begin
                     start_lo <= ioctl_data;
                  end else if (ioctl_addr == START_HI) begin
                     start    <= ADDR_W'({ioctl_data, start_lo});
                     cur_addr <= ADDR_W'({ioctl_data, start_lo});
                     if (type_ok) begin
                        state <= S_BODY;
                     end else begin
                        state    <= S_ERROR;
                        error    <= 1'b1;
                        err_code <= 2'd2;
                     end
                  end
               end
            end
            S_BODY: begin
               if (ioctl_wr) begin
                  mem_addr   <= cur_addr;
                  mem_data   <= ioctl_data;
                  mem_wr     <= 1'b1;
                  ioctl_wait <= 1'b1;
                  state      <= S_WAIT_ACK;
               end else if (!ioctl_download) begin
                  pidx  <= 3'd0;
                  state <= S_PATCH;
                  if (is_mcode) execute_addr <= start;
               end
            end
            S_WAIT_ACK: begin
               // a download drop seen here is picked up once back in BODY
               if (mem_ack) begin
                  mem_wr     <= 1'b0;
                  ioctl_wait <= 1'b0;
                  if (&cur_addr) begin
                     state    <= S_ERROR;
                     error    <= 1'b1;
                     err_code <= 2'd3;
                  end else begin
                     cur_addr <= cur_addr + 1'b1;
                     state    <= S_BODY;
                  end
               end
            end
            S_PATCH: begin
               mem_addr   <= ADDR_W'(p_addr);
               mem_data   <= p_data;
               mem_wr     <= 1'b1;
               ioctl_wait <= 1'b1;
               state      <= S_PATCH_ACK;
            end
            S_PATCH_ACK: begin
               if (mem_ack) begin
                  mem_wr     <= 1'b0;
                  ioctl_wait <= 1'b0;
                  if (!p_last) begin
                     pidx  <= pidx + 3'd1;
                     state <= S_PATCH;
                  end else if (is_mcode) begin
                     state <= S_EXEC;
                  end else begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end
               end
            end
            S_EXEC: begin
               execute_enable <= AUTO_EXEC;
               done           <= 1'b1;
               state          <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vz_image_loader.sv
// Directed bench for vz_image_loader: RAM model with programmable ack delay, one task per scenario.
module tb_vz_image_loader;

   logic        I_CLK = 1'b0;
   logic        I_RST;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [23:0] ioctl_addr;
   logic [7:0]  ioctl_data;
   logic        ioctl_wait;
   logic [15:0] mem_addr;
   logic [7:0]  mem_data;
   logic        mem_wr;
   logic        mem_ack;
   logic        busy, done, error, execute_enable, led;
   logic [1:0]  err_code;
   logic [15:0] execute_addr;

   int total = 0;
   int bad   = 0;

   logic [7:0] ram [0:65535];
   int wr_cnt   = 0;
   int exec_cnt = 0;
   int ack_cnt  = 0;
   int ack_dly  = 0;

   vz_image_loader dut (
      .I_CLK(I_CLK), .I_RST(I_RST),
      .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
      .ioctl_data(ioctl_data), .ioctl_wait(ioctl_wait),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr(mem_wr), .mem_ack(mem_ack),
      .busy(busy), .done(done), .error(error), .err_code(err_code),
      .execute_addr(execute_addr), .execute_enable(execute_enable), .led(led)
   );

   always #5 I_CLK = ~I_CLK;

   // ack arrives on the (ack_dly+1)-th cycle that mem_wr is high
   assign mem_ack = mem_wr && (ack_cnt >= ack_dly);

   always @(posedge I_CLK) begin
      if (mem_wr && !mem_ack) ack_cnt <= ack_cnt + 1;
      else                    ack_cnt <= 0;
      if (mem_wr && mem_ack) begin
         ram[mem_addr] <= mem_data;
         wr_cnt        <= wr_cnt + 1;
      end
      if (execute_enable) exec_cnt <= exec_cnt + 1;
   end

   task automatic send_byte(input logic [23:0] a, input logic [7:0] d, output int wcyc);
      int n;
      @(negedge I_CLK);
      ioctl_addr = a; ioctl_data = d; ioctl_wr = 1'b1;
      @(negedge I_CLK);
      ioctl_wr = 1'b0;
      n = 0; wcyc = 0;
      while (ioctl_wait && n < 200) begin wcyc++; n++; @(negedge I_CLK); end
      total++;
      if (ioctl_wait !== 1'b0) begin
         bad++; $display("FAIL wait_release addr=%0d: ioctl_wait=%b after %0d cycles, want 0", a, ioctl_wait, n);
      end
   endtask

   task automatic send_header(input logic [7:0] m0, input logic [7:0] m1, input logic [7:0] ty,
                              input logic [15:0] st, input int nbytes);
      int w;
      logic [7:0] b;
      for (int i = 0; i < nbytes; i++) begin
         b = 8'h00;
         if (i == 0)  b = m0;
         if (i == 1)  b = m1;
         if (i == 21) b = ty;
         if (i == 22) b = st[7:0];
         if (i == 23) b = st[15:8];
         send_byte(24'(i), b, w);
      end
   endtask

   task automatic send_body(input int n, input logic [7:0] base, output int wsum);
      int w;
      wsum = 0;
      for (int i = 0; i < n; i++) begin
         send_byte(24'(24 + i), base + 8'(i), w);
         wsum += w;
      end
   endtask

   task automatic start_dl();
      @(negedge I_CLK); ioctl_download = 1'b1;
      @(negedge I_CLK);
   endtask

   task automatic end_dl();
      int n;
      @(negedge I_CLK); ioctl_download = 1'b0;
      n = 0;
      @(negedge I_CLK);
      while (busy && n < 500) begin n++; @(negedge I_CLK); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL end_timeout: busy=%b after %0d cycles, want 0", busy, n); end
      repeat (3) @(negedge I_CLK);
   endtask

   task automatic test_reset();
      I_RST = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_data = '0;
      repeat (3) @(negedge I_CLK);
      total++;
      if ({mem_wr, ioctl_wait, busy, done, error, execute_enable, led} !== 7'b0) begin
         bad++; $display("FAIL reset_flags: got %b want 0000000", {mem_wr, ioctl_wait, busy, done, error, execute_enable, led});
      end
      total++;
      if ({err_code, mem_addr, mem_data, execute_addr} !== 42'h0) begin
         bad++; $display("FAIL reset_values: err=%0d addr=%h data=%h exec=%h want all 0", err_code, mem_addr, mem_data, execute_addr);
      end
      I_RST = 1'b0;
      @(negedge I_CLK);
   endtask

   task automatic test_basic();
      logic [15:0] pa [8] = '{16'h78A5, 16'h78A4, 16'h78FA, 16'h78F9, 16'h78FC, 16'h78FB, 16'h78FE, 16'h78FD};
      logic [7:0]  pd [8] = '{8'h7A, 8'hE9, 8'h7A, 8'hEE, 8'h7A, 8'hEE, 8'h7A, 8'hEE};
      int w0, e0, ws;
      w0 = wr_cnt; e0 = exec_cnt; ack_dly = 0;
      start_dl();
      total++;
      if (busy !== 1'b1 || led !== 1'b1) begin bad++; $display("FAIL basic_busy: busy=%b led=%b want 1 1", busy, led); end
      send_header(8'h56, 8'h5A, 8'hF0, 16'h7AE9, 24);
      send_body(5, 8'h10, ws);
      total++;
      if (ws !== 5) begin bad++; $display("FAIL basic_wait: %0d wait cycles, want 5", ws); end
      end_dl();
      for (int i = 0; i < 5; i++) begin
         total++;
         if (ram[16'h7AE9 + 16'(i)] !== 8'h10 + 8'(i)) begin
            bad++; $display("FAIL basic_body[%0d]: got %h want %h", i, ram[16'h7AE9 + 16'(i)], 8'h10 + 8'(i));
         end
      end
      for (int i = 0; i < 8; i++) begin
         total++;
         if (ram[pa[i]] !== pd[i]) begin bad++; $display("FAIL basic_patch %h: got %h want %h", pa[i], ram[pa[i]], pd[i]); end
      end
      total++;
      if (wr_cnt - w0 !== 13) begin bad++; $display("FAIL basic_wrcount: got %0d want 13", wr_cnt - w0); end
      total++;
      if (done !== 1'b1 || error !== 1'b0 || exec_cnt != e0) begin
         bad++; $display("FAIL basic_status: done=%b error=%b exec=%0d want 1 0 0", done, error, exec_cnt - e0);
      end
   endtask

   task automatic test_mcode();
      int w0, e0, ws;
      w0 = wr_cnt; e0 = exec_cnt; ack_dly = 2;
      start_dl();
      send_header(8'h56, 8'h5A, 8'hF1, 16'h8000, 24);
      send_body(3, 8'hC3, ws);
      total++;
      if (ws !== 9) begin bad++; $display("FAIL mcode_wait: %0d wait cycles, want 9", ws); end
      end_dl();
      ack_dly = 0;
      total++;
      if ({ram[16'h8000], ram[16'h8001], ram[16'h8002]} !== 24'hC3C4C5) begin
         bad++; $display("FAIL mcode_body: got %h%h%h want c3c4c5", ram[16'h8000], ram[16'h8001], ram[16'h8002]);
      end
      total++;
      if (ram[16'h788E] !== 8'h00 || ram[16'h788F] !== 8'h80) begin
         bad++; $display("FAIL mcode_vector: 788e=%h 788f=%h want 00 80", ram[16'h788E], ram[16'h788F]);
      end
      total++;
      if (exec_cnt - e0 !== 1) begin bad++; $display("FAIL mcode_exec_pulses: got %0d want 1", exec_cnt - e0); end
      total++;
      if (execute_addr !== 16'h8000 || done !== 1'b1 || wr_cnt - w0 !== 5) begin
         bad++; $display("FAIL mcode_status: exec_addr=%h done=%b writes=%0d want 8000 1 5", execute_addr, done, wr_cnt - w0);
      end
   endtask

   task automatic test_bad_magic();
      int w0;
      w0 = wr_cnt;
      start_dl();
      send_header(8'h58, 8'h58, 8'hF0, 16'h9000, 24);
      end_dl();
      total++;
      if (error !== 1'b1 || err_code !== 2'd1 || done !== 1'b0) begin
         bad++; $display("FAIL magic_status: error=%b code=%0d done=%b want 1 1 0", error, err_code, done);
      end
      total++;
      if (wr_cnt - w0 !== 0) begin bad++; $display("FAIL magic_writes: got %0d want 0", wr_cnt - w0); end
   endtask

   task automatic test_bad_type();
      int w0, ws;
      w0 = wr_cnt;
      start_dl();
      send_header(8'h56, 8'h5A, 8'hF5, 16'h9000, 24);
      send_body(2, 8'h11, ws);
      end_dl();
      total++;
      if (error !== 1'b1 || err_code !== 2'd2 || wr_cnt - w0 !== 0) begin
         bad++; $display("FAIL type_status: error=%b code=%0d writes=%0d want 1 2 0", error, err_code, wr_cnt - w0);
      end
      // a new download clears the error; empty BASIC body patches with end == start
      start_dl();
      total++;
      if (error !== 1'b0 || err_code !== 2'd0 || busy !== 1'b1) begin
         bad++; $display("FAIL type_clear: error=%b code=%0d busy=%b want 0 0 1", error, err_code, busy);
      end
      send_header(8'h56, 8'h5A, 8'hF0, 16'h9000, 24);
      end_dl();
      total++;
      if (done !== 1'b1 || error !== 1'b0 || wr_cnt - w0 !== 8) begin
         bad++; $display("FAIL empty_status: done=%b error=%b writes=%0d want 1 0 8", done, error, wr_cnt - w0);
      end
      total++;
      if (ram[16'h78F9] !== 8'h00 || ram[16'h78FA] !== 8'h90) begin
         bad++; $display("FAIL empty_end: 78f9=%h 78fa=%h want 00 90", ram[16'h78F9], ram[16'h78FA]);
      end
   endtask

   task automatic test_truncated();
      int w0;
      w0 = wr_cnt;
      start_dl();
      send_header(8'h56, 8'h5A, 8'hF0, 16'h9100, 10);
      end_dl();
      total++;
      if (error !== 1'b1 || err_code !== 2'd3 || wr_cnt - w0 !== 0) begin
         bad++; $display("FAIL trunc_status: error=%b code=%0d writes=%0d want 1 3 0", error, err_code, wr_cnt - w0);
      end
   endtask

   task automatic test_wrap();
      int w0, ws;
      w0 = wr_cnt;
      start_dl();
      send_header(8'h56, 8'h5A, 8'hF0, 16'hFFFE, 24);
      send_body(4, 8'hA0, ws);
      end_dl();
      total++;
      if (ram[16'hFFFE] !== 8'hA0 || ram[16'hFFFF] !== 8'hA1) begin
         bad++; $display("FAIL wrap_body: fffe=%h ffff=%h want a0 a1", ram[16'hFFFE], ram[16'hFFFF]);
      end
      total++;
      if (error !== 1'b1 || err_code !== 2'd3 || done !== 1'b0 || wr_cnt - w0 !== 2) begin
         bad++; $display("FAIL wrap_status: error=%b code=%0d done=%b writes=%0d want 1 3 0 2", error, err_code, done, wr_cnt - w0);
      end
   endtask

   task automatic test_reset_in_patch();
      int w0, e0, ws, n;
      w0 = wr_cnt; e0 = exec_cnt; ack_dly = 0;
      start_dl();
      send_header(8'h56, 8'h5A, 8'hF1, 16'hA000, 24);
      send_body(1, 8'h55, ws);
      ack_dly = 20;
      @(negedge I_CLK); ioctl_download = 1'b0;
      n = 0;
      while (!(mem_wr && mem_addr == 16'h788F) && n < 50) begin n++; @(negedge I_CLK); end
      total++;
      if (!(mem_wr && mem_addr == 16'h788F)) begin bad++; $display("FAIL rst_patch_reach: mem_wr=%b addr=%h want 1 788f", mem_wr, mem_addr); end
      I_RST = 1'b1;
      @(negedge I_CLK);
      total++;
      if (mem_wr !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL rst_patch_state: mem_wr=%b busy=%b done=%b want 0 0 0", mem_wr, busy, done);
      end
      I_RST = 1'b0; ack_dly = 0;
      repeat (10) @(negedge I_CLK);
      total++;
      if (exec_cnt - e0 !== 0 || wr_cnt - w0 !== 1 || busy !== 1'b0) begin
         bad++; $display("FAIL rst_patch_after: exec=%0d writes=%0d busy=%b want 0 1 0", exec_cnt - e0, wr_cnt - w0, busy);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_mcode();
      test_bad_magic();
      test_bad_type();
      test_truncated();
      test_wrap();
      test_reset_in_patch();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
